// File: rtl/avmm_cfg_bridge_if.sv
`timescale 1ns/1ps
// Avalon-MM slave port plus 16-bit configuration-bus master port of the cfg bridge.
// Ports: avs_* (CPU-facing 8-bit register window), cfg_* (req/ack configuration bus).
// Modports: slave = bridge view, master = CPU/config-bus environment view.
interface avmm_cfg_bridge_if;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [7:0]  avs_writedata;
  logic [7:0]  avs_readdata;
  logic        avs_waitrequest;
  logic        avs_readdatavalid;
  logic [15:0] cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_req;
  logic        cfg_wr;
  logic        cfg_ack;
  logic [15:0] cfg_rdata;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, cfg_ack, cfg_rdata,
    output avs_readdata, avs_waitrequest, avs_readdatavalid,
    output cfg_addr, cfg_wdata, cfg_req, cfg_wr
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, cfg_ack, cfg_rdata,
    input  avs_readdata, avs_waitrequest, avs_readdatavalid,
    input  cfg_addr, cfg_wdata, cfg_req, cfg_wr
  );
endinterface

// File: rtl/avmm_cfg_bridge.sv
`timescale 1ns/1ps
// Bridges an 8-bit Avalon-MM register window onto a 16-bit req/ack configuration bus.
// Latency: read data 1 cycle after accept; cfg_req 1 cycle after start; busy clears 2 cycles after cfg_ack.
// Backpressure: only a start write (DATA_HI, or CMD bit0) while busy stalls via combinational waitrequest.
// Ports: clk, reset (async, active-high), bus (avmm_cfg_bridge_if.slave: avs_* and cfg_* signals).
module avmm_cfg_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  avmm_cfg_bridge_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYC);

  state_t      state;
  logic [7:0]  addr_lo, addr_hi, data_lo, data_hi, rd_lo, rd_hi;
  logic        busy, done_flag, timeout_flag;
  logic [15:0] cnt;

  logic [2:0]  reg_sel;
  logic [4:0]  addr_unused;
  logic        start_wr, start_rd, start, stall, wr_acc, rd_acc;
  logic [7:0]  rd_mux;

  assign reg_sel     = bus.avs_address[2:0];
  assign addr_unused = bus.avs_address[7:3];

  // Write wins over a simultaneous read; only transaction starts can stall.
  assign start_wr = bus.avs_write && (reg_sel == 3'd3);
  assign start_rd = bus.avs_write && (reg_sel == 3'd4) && bus.avs_writedata[0];
  assign start    = start_wr || start_rd;
  assign stall    = start && (state != IDLE);
  assign wr_acc   = bus.avs_write && !stall;
  assign rd_acc   = bus.avs_read && !bus.avs_write;

  assign bus.avs_waitrequest = stall;

  always_comb begin
    rd_mux = 8'h00;
    case (reg_sel)
      3'd0: rd_mux = addr_lo;
      3'd1: rd_mux = addr_hi;
      3'd2: rd_mux = data_lo;
      3'd3: rd_mux = data_hi;
      3'd5: rd_mux = {5'b0, timeout_flag, done_flag, busy};
      3'd6: rd_mux = rd_lo;
      3'd7: rd_mux = rd_hi;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      addr_lo               <= '0;
      addr_hi               <= '0;
      data_lo               <= '0;
      data_hi               <= '0;
      rd_lo                 <= '0;
      rd_hi                 <= '0;
      busy                  <= 1'b0;
      done_flag             <= 1'b0;
      timeout_flag          <= 1'b0;
      cnt                   <= '0;
      bus.cfg_addr          <= '0;
      bus.cfg_wdata         <= '0;
      bus.cfg_req           <= 1'b0;
      bus.cfg_wr            <= 1'b0;
      bus.avs_readdata      <= '0;
      bus.avs_readdatavalid <= 1'b0;
    end else begin
      bus.avs_readdatavalid <= rd_acc;
      if (rd_acc)
        bus.avs_readdata <= rd_mux;

      if (wr_acc) begin
        case (reg_sel)
          3'd0: addr_lo <= bus.avs_writedata;
          3'd1: addr_hi <= bus.avs_writedata;
          3'd2: data_lo <= bus.avs_writedata;
          3'd3: data_hi <= bus.avs_writedata;
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          // start never stalls in IDLE, so it is always accepted here
          if (start) begin
            state        <= REQ;
            bus.cfg_req  <= 1'b1;
            bus.cfg_addr <= {addr_hi, addr_lo};
            bus.cfg_wr   <= start_wr;
            if (start_wr)
              bus.cfg_wdata <= {bus.avs_writedata, data_lo};
            busy         <= 1'b1;
            done_flag    <= 1'b0;
            timeout_flag <= 1'b0;
            cnt          <= TIMEOUT_LOAD;
          end
        end
        REQ: begin
          // ack is tested first so it beats a simultaneous counter expiry
          if (bus.cfg_ack) begin
            state       <= DONE;
            bus.cfg_req <= 1'b0;
            done_flag   <= 1'b1;
            if (!bus.cfg_wr)
              {rd_hi, rd_lo} <= bus.cfg_rdata;
          end else if (cnt == 16'd0) begin
            state        <= DONE;
            bus.cfg_req  <= 1'b0;
            done_flag    <= 1'b1;
            timeout_flag <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_cfg_bridge.sv
`timescale 1ns/1ps
module tb_avmm_cfg_bridge;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
  } cfg_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] rd_q[$];
  cfg_exp_t   cfg_q[$];
  logic       rd_pend = 1'b0;
  logic       req_prev = 1'b0;

  avmm_cfg_bridge_if bus();

  avmm_cfg_bridge #(.TIMEOUT_CYC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1);
  end

  // Read acceptance as seen by the bench: read without write at the clock edge.
  always @(posedge clk or posedge reset) begin
    if (reset) rd_pend <= 1'b0;
    else       rd_pend <= bus.avs_read && !bus.avs_write;
  end

  // Read-data scoreboard: readdatavalid must match acceptance exactly one cycle later.
  always @(negedge clk) begin
    if (rd_pend || bus.avs_readdatavalid) begin
      checks++;
      if (bus.avs_readdatavalid !== rd_pend) begin
        errors++;
        $display("FAIL rdv_timing: readdatavalid=%b required %b at %0t", bus.avs_readdatavalid, rd_pend, $time);
      end else if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: readdata=%h with no expectation", bus.avs_readdata);
      end else begin
        logic [7:0] e;
        e = rd_q.pop_front();
        if (bus.avs_readdata !== e) begin
          errors++;
          $display("FAIL rd_data: got %h required %h at %0t", bus.avs_readdata, e, $time);
        end
      end
    end
  end

  // Config-bus scoreboard: every cfg_req rising edge must match the next expected request.
  always @(negedge clk) begin
    if (bus.cfg_req === 1'b1 && req_prev !== 1'b1) begin
      checks++;
      if (cfg_q.size() == 0) begin
        errors++;
        $display("FAIL cfg_unexpected: addr=%h wr=%b", bus.cfg_addr, bus.cfg_wr);
      end else begin
        cfg_exp_t e;
        e = cfg_q.pop_front();
        if (bus.cfg_addr !== e.addr || bus.cfg_wr !== e.wr || (e.wr && bus.cfg_wdata !== e.wdata)) begin
          errors++;
          $display("FAIL cfg_req_fields: addr=%h wr=%b wdata=%h required addr=%h wr=%b wdata=%h",
                   bus.cfg_addr, bus.cfg_wr, bus.cfg_wdata, e.addr, e.wr, e.wdata);
        end
      end
    end
    req_prev = bus.cfg_req;
  end

  // Avalon write; returns at the negedge after acceptance with the number of stalled cycles.
  task automatic avs_wr(input logic [7:0] a, input logic [7:0] d, output int stalls);
    bit acc;
    acc = 1'b0;
    stalls = 0;
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (!bus.avs_waitrequest) begin
        acc = 1'b1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL wr_accept: addr %h still stalled after %0d cycles, required accept", a, stalls);
    end
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [7:0] a, input logic [7:0] exp);
    rd_q.push_back(exp);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
  endtask

  task automatic test_reset();
    bus.avs_address = '0; bus.avs_writedata = '0;
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    bus.cfg_ack = 1'b0; bus.cfg_rdata = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.avs_waitrequest !== 1'b0 || bus.cfg_req !== 1'b0 || bus.cfg_wr !== 1'b0 ||
        bus.avs_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: wreq=%b req=%b wr=%b rdv=%b required all 0",
               bus.avs_waitrequest, bus.cfg_req, bus.cfg_wr, bus.avs_readdatavalid);
    end
    checks++;
    if (bus.cfg_addr !== 16'h0 || bus.cfg_wdata !== 16'h0 || bus.avs_readdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h required 0", bus.cfg_addr, bus.cfg_wdata, bus.avs_readdata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.avs_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_wreq: got %b required 0", bus.avs_waitrequest);
    end
    for (int i = 0; i < 8; i++) avs_rd(8'(i), 8'h00);
  endtask

  task automatic test_write();
    int s, tot, len;
    tot = 0;
    avs_wr(8'h00, 8'h34, s); tot += s;
    avs_wr(8'h01, 8'h12, s); tot += s;
    avs_wr(8'h02, 8'hEF, s); tot += s;
    cfg_q.push_back('{addr: 16'h1234, wdata: 16'hBEEF, wr: 1'b1});
    avs_wr(8'h03, 8'hBE, s); tot += s;
    checks++;
    if (tot != 0) begin
      errors++;
      $display("FAIL write_stalls: got %0d required 0", tot);
    end
    len = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cfg_req !== 1'b1) break;
      len++;
      if (len == 3) bus.cfg_ack = 1'b1;
      @(negedge clk);
      bus.cfg_ack = 1'b0;
    end
    checks++;
    if (len != 3) begin
      errors++;
      $display("FAIL write_burst_len: got %0d required 3", len);
    end
    avs_rd(8'h05, 8'h03);   // DONE: busy still set
    avs_rd(8'h05, 8'h02);   // IDLE: busy cleared
    avs_rd(8'h00, 8'h34);
    avs_rd(8'h01, 8'h12);
    avs_rd(8'h02, 8'hEF);
    avs_rd(8'hFB, 8'hBE);   // upper address bits ignored
  endtask

  task automatic test_read();
    int s;
    avs_wr(8'h00, 8'h20, s);
    avs_wr(8'h01, 8'h00, s);
    avs_wr(8'h04, 8'h02, s);
    checks++;
    if (bus.cfg_req !== 1'b0) begin
      errors++;
      $display("FAIL cmd_bit0_clear: cfg_req=%b required 0", bus.cfg_req);
    end
    cfg_q.push_back('{addr: 16'h0020, wdata: 16'h0000, wr: 1'b0});
    avs_wr(8'h04, 8'h01, s);
    checks++;
    if (bus.cfg_req !== 1'b1 || bus.cfg_wr !== 1'b0) begin
      errors++;
      $display("FAIL read_req: req=%b wr=%b required 1 0", bus.cfg_req, bus.cfg_wr);
    end
    bus.cfg_ack = 1'b1; bus.cfg_rdata = 16'hA55A;
    @(negedge clk);
    bus.cfg_ack = 1'b0; bus.cfg_rdata = 16'h0000;
    checks++;
    if (bus.cfg_req !== 1'b0) begin
      errors++;
      $display("FAIL read_req_drop: cfg_req=%b required 0", bus.cfg_req);
    end
    @(negedge clk);
    avs_rd(8'h06, 8'h5A);
    avs_rd(8'h07, 8'hA5);
    avs_rd(8'h05, 8'h02);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.avs_readdata !== 8'h02 || bus.avs_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL rdata_hold: rdata=%h rdv=%b required 02 0", bus.avs_readdata, bus.avs_readdatavalid);
    end
    // read+write together: handled as a write, no readdatavalid
    bus.avs_address = 8'h00; bus.avs_writedata = 8'h55;
    bus.avs_read = 1'b1; bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    checks++;
    if (bus.avs_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL rw_collision_rdv: got %b required 0", bus.avs_readdatavalid);
    end
    avs_rd(8'h00, 8'h55);
  endtask

  task automatic test_timeout();
    int s, len;
    cfg_q.push_back('{addr: 16'h0055, wdata: 16'h0000, wr: 1'b0});
    avs_wr(8'h04, 8'h01, s);
    len = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cfg_req !== 1'b1) break;
      len++;
      @(negedge clk);
    end
    checks++;
    if (len != 5) begin
      errors++;
      $display("FAIL timeout_len: got %0d required 5", len);
    end
    @(negedge clk);
    avs_rd(8'h05, 8'h06);
    avs_rd(8'h06, 8'h5A);
    avs_rd(8'h07, 8'hA5);
  endtask

  task automatic test_ack_at_zero();
    int s, len;
    cfg_q.push_back('{addr: 16'h0055, wdata: 16'h0000, wr: 1'b0});
    avs_wr(8'h04, 8'h01, s);
    len = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cfg_req !== 1'b1) break;
      len++;
      if (len == 5) begin
        bus.cfg_ack = 1'b1; bus.cfg_rdata = 16'h1337;
      end
      @(negedge clk);
      bus.cfg_ack = 1'b0; bus.cfg_rdata = 16'h0000;
    end
    checks++;
    if (len != 5) begin
      errors++;
      $display("FAIL ack_zero_len: got %0d required 5", len);
    end
    @(negedge clk);
    avs_rd(8'h05, 8'h02);
    avs_rd(8'h06, 8'h37);
    avs_rd(8'h07, 8'h13);
    // stray ack in IDLE
    bus.cfg_ack = 1'b1; bus.cfg_rdata = 16'hFFFF;
    repeat (2) @(negedge clk);
    bus.cfg_ack = 1'b0; bus.cfg_rdata = 16'h0000;
    checks++;
    if (bus.cfg_req !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack_req: cfg_req=%b required 0", bus.cfg_req);
    end
    avs_rd(8'h05, 8'h02);
    avs_rd(8'h06, 8'h37);
  endtask

  task automatic test_back_to_back();
    int s, s2;
    avs_wr(8'h00, 8'h40, s);
    avs_wr(8'h01, 8'h00, s);
    avs_wr(8'h02, 8'h11, s);
    cfg_q.push_back('{addr: 16'h0040, wdata: 16'h2211, wr: 1'b1});
    avs_wr(8'h03, 8'h22, s);
    checks++;
    if (bus.cfg_req !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_req: cfg_req=%b required 1", bus.cfg_req);
    end
    avs_wr(8'h02, 8'h33, s);
    checks++;
    if (s != 0) begin
      errors++;
      $display("FAIL b2b_datalo_stall: got %0d required 0", s);
    end
    cfg_q.push_back('{addr: 16'h0040, wdata: 16'h4433, wr: 1'b1});
    fork
      begin
        repeat (2) @(negedge clk);
        bus.cfg_ack = 1'b1;
        @(negedge clk);
        bus.cfg_ack = 1'b0;
      end
      avs_wr(8'h03, 8'h44, s2);
    join
    checks++;
    if (s2 != 4) begin
      errors++;
      $display("FAIL b2b_stall_cycles: got %0d required 4", s2);
    end
    checks++;
    if (bus.cfg_req !== 1'b1 || bus.cfg_wdata !== 16'h4433) begin
      errors++;
      $display("FAIL b2b_second_req: req=%b wdata=%h required 1 4433", bus.cfg_req, bus.cfg_wdata);
    end
    bus.cfg_ack = 1'b1;
    @(negedge clk);
    bus.cfg_ack = 1'b0;
    @(negedge clk);
    avs_rd(8'h05, 8'h02);
    avs_rd(8'h02, 8'h33);
    avs_rd(8'h03, 8'h44);
  endtask

  task automatic test_reset_mid();
    int s;
    cfg_q.push_back('{addr: 16'h0040, wdata: 16'h7733, wr: 1'b1});
    avs_wr(8'h03, 8'h77, s);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.cfg_req !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_req: cfg_req=%b required 0", bus.cfg_req);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cfg_addr !== 16'h0 || bus.cfg_wdata !== 16'h0 || bus.cfg_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_cfg: addr=%h wdata=%h req=%b required 0", bus.cfg_addr, bus.cfg_wdata, bus.cfg_req);
    end
    for (int i = 0; i < 8; i++) avs_rd(8'(i), 8'h00);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_at_zero();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (rd_q.size() != 0 || cfg_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: rd pending %0d cfg pending %0d required 0 0", rd_q.size(), cfg_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avmm_cfg_bridge.md
AVMM_CFG_BRIDGE -- requirements
Module: avmm_cfg_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning cycles to wait for cfg_ack before abort (1..65535).
REQ-002 SHALL have port clk  in  1  single clock for all logic.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port avs_address  in  8  Avalon-MM slave byte address; driven by the CPU 8-bit master port.
REQ-005 SHALL have ports avs_read, avs_write  in  1 each  Avalon-MM slave read and write strobes.
REQ-006 SHALL have port avs_writedata  in  8  Avalon-MM slave write data.
REQ-007 SHALL have port avs_readdata  out  8  Avalon-MM slave read data.
REQ-008 SHALL have ports avs_waitrequest, avs_readdatavalid  out  1 each  Avalon-MM slave stall and read-data-valid.
REQ-009 SHALL have port cfg_addr  out  16  configuration bus address.
REQ-010 SHALL have port cfg_wdata  out  16  configuration bus write data.
REQ-011 SHALL have ports cfg_req, cfg_wr  out  1 each  cfg_req = request; cfg_wr = 1 for write, 0 for read.
REQ-012 SHALL have port cfg_ack  in  1  configuration bus completion.
REQ-013 SHALL have port cfg_rdata  in  16  configuration bus read data, valid when cfg_ack=1.

Function
REQ-014 Register map (bits [2:0] decoded; [7:3] ignored): 0 ADDR_LO, 1 ADDR_HI, 2 DATA_LO, 3 DATA_HI (write = start cfg write), 4 CMD (write bit0=1 = start cfg read), 5 STATUS, 6 RD_LO, 7 RD_HI.
REQ-015 STATUS read value SHALL be {5'b0, timeout_flag, done_flag, busy}.
REQ-016 Registers 0–3 SHALL be read-back; RD_LO/RD_HI SHALL be read-only; writes to 5–7 SHALL be ignored.
REQ-017 Reads SHALL never stall; avs_readdatavalid SHALL pulse exactly 1 cycle after each accepted read; avs_readdata SHALL hold its value otherwise.
REQ-018 Writes to 0–2 SHALL always be accepted with waitrequest low.
REQ-019 A write to 3, or to 4 with bit0=1, while busy=1 SHALL assert avs_waitrequest combinationally until the state returns to IDLE, then complete.
REQ-020 FSM states: IDLE, REQ, DONE.
REQ-021 IDLE->REQ on an accepted start: latch cfg_addr={ADDR_HI,ADDR_LO}; for a write, also latch cfg_wdata={DATA_HI(new),DATA_LO} and set cfg_wr=1; for a read, set cfg_wr=0.
REQ-022 On entering REQ: set busy=1; clear done_flag and timeout_flag; load the timeout counter with TIMEOUT_CYC.
REQ-023 In REQ, cfg_req SHALL be held high until cfg_ack.
REQ-024 REQ->DONE on cfg_ack=1: for a read, capture cfg_rdata into RD_HI:RD_LO in the same cycle; set done_flag.
REQ-025 In REQ, the counter SHALL decrement each cycle without ack; at 0, go to DONE with timeout_flag=1, done_flag=1, and RD registers unchanged.
REQ-026 If cfg_ack and timeout reach 0 in the same cycle, ack SHALL win: timeout_flag=0, data captured.
REQ-027 DONE->IDLE after 1 cycle; cfg_req SHALL be low in DONE; busy SHALL clear on entering IDLE.
REQ-028 cfg_ack while not in REQ SHALL be ignored.
REQ-029 Start-to-cfg_req latency SHALL be 1 cycle; cfg_ack-to-busy-clear latency SHALL be 2 cycles.
REQ-030 Simultaneous avs_read and avs_write SHALL be treated as a write; no readdatavalid SHALL be issued.

Reset
REQ-031 On reset, all registers, flags, cfg_addr, cfg_wdata and avs_readdata SHALL be 0; cfg_req, cfg_wr, avs_readdatavalid and busy SHALL be 0; state SHALL be IDLE.
REQ-032 avs_waitrequest SHALL be 0 during and after reset.
REQ-033 Reset asserted mid-transaction SHALL drop cfg_req immediately (asynchronous) and abandon the transaction.

Verification
REQ-034 Write: ADDR=0x1234, DATA=0xBEEF via regs 0–3, ack 3 cycles later -> single cfg_req burst with cfg_wr=1, addr 0x1234, wdata 0xBEEF; STATUS=0x02.
REQ-035 Read: ADDR=0x0020, CMD=0x01, ack with rdata=0xA55A -> RD_LO=0x5A, RD_HI=0xA5, each readdatavalid 1 cycle after read.
REQ-036 Timeout with TIMEOUT_CYC=4: no ack -> cfg_req drops after 5 REQ cycles; STATUS=0x06; RD unchanged.
REQ-037 Back-to-back: second DATA_HI write while busy -> waitrequest high until IDLE, then second transaction issued with new data.
REQ-038 Reset pulse during REQ -> cfg_req=0 asynchronously; all registers read 0x00 afterwards.
REQ-039 Ack coincident with counter reaching 0 -> timeout_flag=0, data captured; stray ack in IDLE -> no state change.
